// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1, LSB-first serializer on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  data_in,
  input  logic                        wr_en,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        busy,
  output logic                        tx
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif
  logic          wr_ok, pop, baud_end;

  assign full       = (count_q == CNT_FULL);
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign busy       = busy_q;
  assign tx         = tx_q;

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q | (wr_en & full);
    wr_ok    = wr_en & ~full;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    baud_end = (cnt_q == BAUD_LAST);

    case (state_q)
      S_IDLE:   if (count_q != '0) pop = 1'b1;
      S_START:  if (baud_end) begin
                  state_d = S_DATA;
                  bit_d   = 3'd0;
                end
      S_DATA:   if (baud_end) begin
                  if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                  end else begin
                    bit_d   = bit_q + 3'd1;
                    shift_d = {1'b0, shift_q[7:1]};
                  end
                end
      S_PARITY: if (baud_end) state_d = S_STOP;
      S_STOP:   if (baud_end) begin
                  if (count_q != '0) pop = 1'b1;
                  else               state_d = S_IDLE;
                end
      default:  state_d = S_IDLE;
    endcase

    // Stop-to-start chaining goes through the same pop path as leaving IDLE.
    if (pop) begin
      state_d  = S_START;
      shift_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
`ifdef UART_TX_PARITY_EN
      par_d    = ^mem_q[rd_ptr_q];
`endif
    end
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;

    case ({wr_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    cnt_d = (state_q == S_IDLE || baud_end) ? '0 : cnt_q + 1'b1;

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a frame-level queue model of the transmitter.
module tb_uart_tx_fifo;
  localparam int CLK_FREQ = 16;
  localparam int BAUD     = 4;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int DEPTH    = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       full, overflow, busy, tx;
  logic [4:0] fifo_count;

  uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .full(full),
    .fifo_count(fifo_count), .overflow(overflow), .busy(busy), .tx(tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: pending bytes, byte on the wire, clocks elapsed in its frame (-1 = line idle).
  logic [7:0] mq[$];
  logic [7:0] cur = 8'h00;
  int         pos = -1;
  bit         ovf_m = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_tx();
    int b;
    if (pos < 0) return 1'b1;
    b = pos / DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^cur;
`endif
    return 1'b1;
  endfunction

  task automatic model_reset();
    mq.delete();
    pos   = -1;
    ovf_m = 1'b0;
  endtask

  task automatic model_edge(input logic we, input logic [7:0] d);
    int sz = mq.size();
    bit do_pop = 1'b0;
    if (pos < 0) begin
      if (sz > 0) do_pop = 1'b1;
    end else if (pos == FRAME - 1) begin
      if (sz > 0) do_pop = 1'b1;
      else pos = -1;
    end else begin
      pos++;
    end
    if (do_pop) begin
      cur = mq.pop_front();
      pos = 0;
    end
    if (we) begin
      if (sz < DEPTH) mq.push_back(d);
      else ovf_m = 1'b1;
    end
  endtask

  task automatic check_all();
    check_eq("tx", 32'(tx), 32'(exp_tx()));
    check_eq("busy", 32'(busy), 32'(pos >= 0));
    check_eq("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check_eq("full", 32'(full), 32'(mq.size() == DEPTH));
    check_eq("overflow", 32'(overflow), 32'(ovf_m));
  endtask

  task automatic step(input logic we, input logic [7:0] d);
    wr_en   = we;
    data_in = d;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(we, d);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic drain();
    for (int i = 0; i < (DEPTH + 2) * FRAME && (mq.size() > 0 || pos >= 0); i++)
      step(1'b0, 8'h00);
    idle(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int thr;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    rst = 1'b0;
    idle(2);

    // single byte, then two back-to-back bytes
    step(1'b1, 8'h55);
    idle(FRAME + 10);
    step(1'b1, 8'h41);
    step(1'b1, 8'h42);
    drain();
`ifdef UART_TX_PARITY_EN
    step(1'b1, 8'h07);
    step(1'b1, 8'h03);
    drain();
`endif

    // 18-write burst: fills to full, last write dropped
    for (int i = 0; i < 18; i++) step(1'b1, 8'(8'h10 + i));
    drain();

    // long burst so a dropped write lands on a pop edge
    for (int i = 0; i < FRAME + 20; i++) step(1'b1, 8'($urandom));
    drain();

    // randomized traffic at mixed write densities
    for (int blk = 0; blk < 12; blk++) begin
      case ($urandom_range(0, 2))
        0:       thr = 2;
        1:       thr = 16;
        default: thr = 64;
      endcase
      for (int i = 0; i < 200; i++)
        step($urandom_range(0, thr - 1) == 0, 8'($urandom));
    end
    drain();

    // async reset in the middle of a data bit with three bytes queued
    step(1'b1, 8'hA3);
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom));
    idle(3 * DIV);
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    idle(2);
    rst = 1'b0;
    idle(100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit half of the terminal's serial link: buffers bytes from the display/keyboard side in a FIFO and serializes them 8N1, LSB first, onto the UART TX line. Sits beside the existing receive path in the top-level system and drives the board's TX pin. It also provides the echo/host-reply path.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s; bit period DIV = CLK_FREQ/BAUD clocks (integer, truncated; 10416 at defaults)
FIFO_DEPTH, 16, byte entries; power of two, >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
data_in  input  8  byte to enqueue
wr_en  input  1  write strobe; data_in sampled on the clk edge when wr_en=1
full  output  1  FIFO holds FIFO_DEPTH entries
fifo_count  output  log2(FIFO_DEPTH)+1  entries currently buffered
overflow  output  1  sticky: a write was dropped
busy  output  1  frame in progress (FSM not IDLE)
tx  output  1  serial line, registered, idles high

Behaviour:
- One clock; reset is asynchronous and active-high. While rst=1: tx=1, full=0, fifo_count=0, overflow=0, busy=0, FSM=IDLE, baud counter=0, FIFO pointers=0. Outputs take these values immediately on rst assertion, including in the middle of a frame. The partial frame is abandoned and buffered bytes are discarded.
- Write: accepted on an edge where wr_en=1 and full=0; data goes to the tail and fifo_count increments. The full used is the registered value before the edge. A write while full=1 is dropped and sets overflow=1, even if a pop occurs on the same edge. overflow clears only on reset.
- Pop: the FSM removes the head entry on the edge it leaves IDLE or STOP for START. A simultaneous write and pop leaves fifo_count unchanged. No pop occurs when the FIFO is empty. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP (plus PARITY under the option).
- IDLE: tx=1. If fifo_count != 0, pop the head into the shift register, clear the baud counter and go to START.
- START: tx=0 for DIV clocks.
- DATA: tx = shift[0], LSB first. Shift right every DIV clocks; bit index 0..7. After bit 7, go to STOP.
- STOP: tx=1 for DIV clocks. At the end: if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: counts 0..DIV-1 and wraps on state/bit advance. A frame is exactly 10*DIV clocks.
- Latency: a byte written at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. tx falls after edge N+1.
- busy = (state != IDLE), registered alongside state.
- wr_en with data_in is the same strobe/byte convention as the receive path's char/en pair, so RX output can be looped directly into this block.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP; tx = XOR of the 8 data bits (even parity) for DIV clocks. A frame is 11*DIV clocks.
- Undefined: no PARITY state; 8N1, 10*DIV clocks per frame.

Test Plan:
1. Sim params CLK_FREQ=16, BAUD=4 (DIV=4). Reset, then write 0x55 -> tx falls the edge after the pop; line is 0,1,0,1,0,1,0,1,0,1, each held 4 clocks; busy high 40 clocks then IDLE; tx=1 afterwards.
2. Write 0x41, 0x42 on consecutive cycles -> 20 bit periods back-to-back with no high gap between the stop of 0x41 and the start of 0x42; fifo_count goes 1,1,0 across the pops.
3. Overflow, DIV=4, depth 16: 18 writes on consecutive cycles -> 17 bytes accepted (first popped at edge 1); full=1 after the 17th; the 18th is dropped; overflow=1 and stays 1 until reset; the 17 bytes are transmitted in order.
4. Assert rst mid-DATA of 0xA3 with 3 bytes queued -> tx=1, fifo_count=0, busy=0 immediately without waiting for a clk edge. After release with no writes, tx stays 1 for 100 clocks.
5. With UART_TX_PARITY_EN, write 0x07 then 0x03 -> parity bits 1 then 0; each frame 44 clocks.
6. Write while full on the same edge as a pop -> write dropped, overflow=1, fifo_count = 15 after that edge.
